// File: rtl/tristate_bus_port_if.sv
// Handshake and status signals between the internal datapath and tristate_bus_port.
interface tristate_bus_port_if #(
    parameter int unsigned WIDTH = 8
);
    logic             txValid;
    logic [WIDTH-1:0] txData;
    logic             txReady;
    logic             rxStrobe;
    logic [WIDTH-1:0] rxData;
    logic             rxValid;
    logic             busy;

    // Datapath side: offers transmit words and receive requests.
    modport master (
        output txValid, txData, rxStrobe,
        input  txReady, rxData, rxValid, busy
    );

    // Port side: the bus driver itself.
    modport slave (
        input  txValid, txData, rxStrobe,
        output txReady, rxData, rxValid, busy
    );
endinterface

// File: rtl/tristate_bus_port.sv
// Registered, optionally inverting tri-state bus driver with a direction FSM
// that inserts hi-Z turnaround cycles before driving and after releasing.
module tristate_bus_port #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned TURNAROUND = 2,
    parameter bit          INVERT     = 1'b1
) (
    input  logic                clock,
    input  logic                reset_,
    tristate_bus_port_if.slave  port,
    inout  wire  [WIDTH-1:0]    bus_
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((TURNAROUND == 0) ? 0 : TURNAROUND - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TURN_ON  = 2'd1,
        DRIVE    = 2'd2,
        TURN_OFF = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               oe_q, oe_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [WIDTH-1:0]   rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic [WIDTH-1:0]   bus_in;
    logic [WIDTH-1:0]   bus_out;

    // Polarity correction on both directions of the pins.
    assign bus_in  = INVERT ? ~bus_ : bus_;
    assign bus_out = INVERT ? ~out_q : out_q;

    // Pins are driven only from flops, so they change on clock edges (or async reset).
    assign bus_ = oe_q ? bus_out : {WIDTH{1'bz}};

    assign port.txReady = (state_q == DRIVE);
    assign port.busy    = (state_q != IDLE);
    assign port.rxData  = rx_data_q;
    assign port.rxValid = rx_valid_q;

    // State and datapath registers; reset releases the bus without a clock.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            oe_q       <= 1'b0;
            out_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            oe_q       <= oe_d;
            out_q      <= out_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // Direction FSM: next state, turnaround counter, output enable and sampling.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        oe_d       = oe_q;
        out_d      = out_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                oe_d = 1'b0;
                if (port.txValid) begin
                    // Transmit wins over a simultaneous receive request.
                    if (TURNAROUND == 0) begin
                        state_d = DRIVE;
                    end else begin
                        state_d = TURN_ON;
                        cnt_d   = CNT_LOAD;
                    end
                end else if (port.rxStrobe) begin
                    rx_data_d  = bus_in;
                    rx_valid_d = 1'b1;
                end
            end
            TURN_ON: begin
                // Committed once entered; a dropped txValid exits through DRIVE.
                oe_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = DRIVE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DRIVE: begin
                if (port.txValid) begin
                    out_d = port.txData;
                    oe_d  = 1'b1;
                end else begin
                    oe_d = 1'b0;
                    if (TURNAROUND == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = TURN_OFF;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            TURN_OFF: begin
                // Another agent may not drive yet; strobes and txValid are ignored.
                oe_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                oe_d    = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_tristate_bus_port.sv
// Directed bench for tristate_bus_port across three parameter sets with a bus-word scoreboard.
module tb_tristate_bus_port;
    localparam int unsigned W = 8;

    logic clock = 1'b0;
    logic reset_;
    always #5 clock = ~clock;

    int tests;
    int fails;

    tristate_bus_port_if #(.WIDTH(W)) a_if ();
    tristate_bus_port_if #(.WIDTH(W)) b_if ();
    tristate_bus_port_if #(.WIDTH(W)) c_if ();

    wire  [W-1:0] a_bus;
    wire  [W-1:0] b_bus;
    wire  [W-1:0] c_bus;
    logic         a_ext_en;
    logic [W-1:0] a_ext_val;
    logic         b_ext_en;
    logic [W-1:0] b_ext_val;

    // External agents on the shared buses.
    assign a_bus = a_ext_en ? a_ext_val : {W{1'bz}};
    assign b_bus = b_ext_en ? b_ext_val : {W{1'bz}};

    tristate_bus_port #(.WIDTH(W), .TURNAROUND(2), .INVERT(1'b1)) u_a (
        .clock(clock), .reset_(reset_), .port(a_if), .bus_(a_bus));
    tristate_bus_port #(.WIDTH(W), .TURNAROUND(0), .INVERT(1'b0)) u_b (
        .clock(clock), .reset_(reset_), .port(b_if), .bus_(b_bus));
    tristate_bus_port #(.WIDTH(W), .TURNAROUND(15), .INVERT(1'b1)) u_c (
        .clock(clock), .reset_(reset_), .port(c_if), .bus_(c_bus));

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic [W-1:0] qc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then pop/compare a word for every port that is driving.
    task automatic cyc();
        @(posedge clock);
        #1;
        if (u_a.oe_q === 1'b1) begin
            if (qa.size() == 0) chk("a_spurious_drive", 64'(u_a.oe_q), 64'(0));
            else chk("a_bus_word", 64'(a_bus), 64'(qa.pop_front()));
        end
        if (u_b.oe_q === 1'b1) begin
            if (qb.size() == 0) chk("b_spurious_drive", 64'(u_b.oe_q), 64'(0));
            else chk("b_bus_word", 64'(b_bus), 64'(qb.pop_front()));
        end
        if (u_c.oe_q === 1'b1) begin
            if (qc.size() == 0) chk("c_spurious_drive", 64'(u_c.oe_q), 64'(0));
            else chk("c_bus_word", 64'(c_bus), 64'(qc.pop_front()));
        end
    endtask

    // Raise txValid on port A and count hi-Z cycles until txReady.
    task automatic a_launch(input logic [W-1:0] d, output int n);
        a_if.txValid = 1'b1;
        a_if.txData  = d;
        cyc();
        n = 0;
        while (a_if.txReady !== 1'b1 && n < 40) begin
            chk("a_turn_on_hiz", 64'(u_a.oe_q), 64'(0));
            n++;
            cyc();
        end
    endtask

    initial begin
        int n;
        tests = 0;
        fails = 0;
        reset_ = 1'b0;
        a_if.txValid = 1'b0; a_if.txData = '0; a_if.rxStrobe = 1'b0;
        b_if.txValid = 1'b0; b_if.txData = '0; b_if.rxStrobe = 1'b0;
        c_if.txValid = 1'b0; c_if.txData = '0; c_if.rxStrobe = 1'b0;
        a_ext_en = 1'b0; a_ext_val = '0;
        b_ext_en = 1'b0; b_ext_val = '0;

        // Reset state
        cyc(); cyc();
        chk("rst_txready", 64'(a_if.txReady), 64'(0));
        chk("rst_busy", 64'(a_if.busy), 64'(0));
        chk("rst_rxdata", 64'(a_if.rxData), 64'(0));
        chk("rst_rxvalid", 64'(a_if.rxValid), 64'(0));
        chk("rst_oe", 64'(u_a.oe_q), 64'(0));
        reset_ = 1'b1;
        cyc();

        // Burst A5,01,FF on the inverting port with 2-cycle turnaround
        qa.push_back(8'h5A); qa.push_back(8'hFE); qa.push_back(8'h00);
        a_launch(8'hA5, n);
        chk("burst_turn_on_cycles", 64'(n), 64'(2));
        chk("burst_busy", 64'(a_if.busy), 64'(1));
        cyc();
        chk("burst_w0_oe", 64'(u_a.oe_q), 64'(1));
        a_if.txData = 8'h01;
        cyc();
        chk("burst_w1_oe", 64'(u_a.oe_q), 64'(1));
        a_if.txData = 8'hFF;
        cyc();
        chk("burst_w2_oe", 64'(u_a.oe_q), 64'(1));
        a_if.txValid = 1'b0;
        cyc();
        chk("burst_release_oe", 64'(u_a.oe_q), 64'(0));
        chk("burst_release_ready", 64'(a_if.txReady), 64'(0));
        n = 0;
        while (a_if.busy === 1'b1 && n < 40) begin
            chk("burst_turn_off_hiz", 64'(u_a.oe_q), 64'(0));
            n++;
            cyc();
        end
        chk("burst_turn_off_cycles", 64'(n), 64'(2));
        chk("burst_queue_empty", 64'(qa.size()), 64'(0));

        // Receive on the inverting port, then continuous strobes
        a_ext_en = 1'b1; a_ext_val = 8'h0F; a_if.rxStrobe = 1'b1;
        cyc();
        chk("rx_data_f0", 64'(a_if.rxData), 64'(8'hF0));
        chk("rx_valid_1", 64'(a_if.rxValid), 64'(1));
        a_ext_val = 8'h81;
        cyc();
        chk("rx_data_7e", 64'(a_if.rxData), 64'(8'h7E));
        chk("rx_valid_cont", 64'(a_if.rxValid), 64'(1));
        a_if.rxStrobe = 1'b0;
        cyc();
        chk("rx_valid_drop", 64'(a_if.rxValid), 64'(0));
        chk("rx_data_hold", 64'(a_if.rxData), 64'(8'h7E));
        a_ext_en = 1'b0;

        // Strobes during TURN_OFF produce no sample
        qa.push_back(8'hC3);
        a_launch(8'h3C, n);
        chk("toff_turn_on_cycles", 64'(n), 64'(2));
        cyc();
        a_if.txValid = 1'b0;
        cyc();
        a_if.rxStrobe = 1'b1;
        cyc();
        chk("toff_rxvalid_0", 64'(a_if.rxValid), 64'(0));
        chk("toff_busy", 64'(a_if.busy), 64'(1));
        cyc();
        a_if.rxStrobe = 1'b0;
        chk("toff_rxvalid_1", 64'(a_if.rxValid), 64'(0));
        chk("toff_idle", 64'(a_if.busy), 64'(0));
        chk("toff_rxdata_hold", 64'(a_if.rxData), 64'(8'h7E));
        cyc();

        // Collision: transmit wins, then txValid dropped during TURN_ON
        a_if.txValid = 1'b1; a_if.txData = 8'h55; a_if.rxStrobe = 1'b1;
        cyc();
        chk("coll_busy", 64'(a_if.busy), 64'(1));
        chk("coll_rxvalid", 64'(a_if.rxValid), 64'(0));
        chk("coll_txready", 64'(a_if.txReady), 64'(0));
        a_if.txValid = 1'b0; a_if.rxStrobe = 1'b0;
        cyc();
        chk("coll_turn_on2", 64'(a_if.txReady), 64'(0));
        cyc();
        chk("coll_drive_ready", 64'(a_if.txReady), 64'(1));
        chk("coll_drive_oe", 64'(u_a.oe_q), 64'(0));
        cyc();
        n = 0;
        while (a_if.busy === 1'b1 && n < 40) begin
            chk("coll_hiz", 64'(u_a.oe_q), 64'(0));
            n++;
            cyc();
        end
        chk("coll_turn_off_cycles", 64'(n), 64'(2));
        chk("coll_rxdata_hold", 64'(a_if.rxData), 64'(8'h7E));

        // Async reset mid-DRIVE while bus shows 3C
        qa.push_back(8'h3C);
        a_launch(8'hC3, n);
        cyc();
        chk("rst_mid_oe_before", 64'(u_a.oe_q), 64'(1));
        #2;
        reset_ = 1'b0;
        #1;
        chk("rst_mid_oe", 64'(u_a.oe_q), 64'(0));
        chk("rst_mid_txready", 64'(a_if.txReady), 64'(0));
        chk("rst_mid_busy", 64'(a_if.busy), 64'(0));
        chk("rst_mid_rxdata", 64'(a_if.rxData), 64'(0));
        a_if.txValid = 1'b0;
        #2;
        reset_ = 1'b1;
        cyc();
        chk("rst_mid_idle", 64'(a_if.busy), 64'(0));

        // True polarity, no turnaround: single word 81
        b_if.txValid = 1'b1; b_if.txData = 8'h81;
        qb.push_back(8'h81);
        cyc();
        chk("b_ready_next", 64'(b_if.txReady), 64'(1));
        chk("b_oe_pre", 64'(u_b.oe_q), 64'(0));
        cyc();
        chk("b_oe_word", 64'(u_b.oe_q), 64'(1));
        b_if.txValid = 1'b0;
        cyc();
        chk("b_release_oe", 64'(u_b.oe_q), 64'(0));
        chk("b_idle_busy", 64'(b_if.busy), 64'(0));
        chk("b_idle_ready", 64'(b_if.txReady), 64'(0));
        chk("b_queue_empty", 64'(qb.size()), 64'(0));
        b_ext_en = 1'b1; b_ext_val = 8'h5A; b_if.rxStrobe = 1'b1;
        cyc();
        b_if.rxStrobe = 1'b0; b_ext_en = 1'b0;
        chk("b_rx_data", 64'(b_if.rxData), 64'(8'h5A));
        chk("b_rx_valid", 64'(b_if.rxValid), 64'(1));

        // Maximum turnaround of 15 on both sides
        c_if.txValid = 1'b1; c_if.txData = 8'h12;
        qc.push_back(8'hED);
        cyc();
        n = 0;
        while (c_if.txReady !== 1'b1 && n < 40) begin
            n++;
            cyc();
        end
        chk("c_turn_on_cycles", 64'(n), 64'(15));
        cyc();
        chk("c_oe_word", 64'(u_c.oe_q), 64'(1));
        c_if.txValid = 1'b0;
        cyc();
        n = 0;
        while (c_if.busy === 1'b1 && n < 40) begin
            if (u_c.oe_q !== 1'b0) chk("c_turn_off_hiz", 64'(u_c.oe_q), 64'(0));
            n++;
            cyc();
        end
        chk("c_turn_off_cycles", 64'(n), 64'(15));
        chk("c_queue_empty", 64'(qc.size()), 64'(0));
        chk("a_queue_empty", 64'(qa.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
